button_conditioner: RTL and testbench

Multi-channel front end for raw push-buttons and slide switches. Each channel synchronises, debounces and edge-detects its input, and classifies each hold as short or long, with optional auto-repeat while the button stays down. It replaces the separate switch, debounce and single-pulse chain between board pins and control FSMs. Downstream logic gets clean one-cycle events.

---
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: per channel two-flop synchroniser,
// debounce, press/release edge pulses, and a hold classifier that emits a
// long-press pulse followed by optional periodic auto-repeat pulses.
// The release pulse output is named release_pulse because `release` is a
// reserved word in SystemVerilog.
module button_conditioner #(
   parameter int unsigned BUTTON_WIDTH     = 1,
   parameter int unsigned DEBOUNCE_COUNT   = 32'd1_000_000,
   parameter int unsigned LONG_PRESS_COUNT = 32'd50_000_000,
   parameter int unsigned REPEAT_COUNT     = 32'd10_000_000,
   parameter int unsigned CNT_WIDTH        = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [BUTTON_WIDTH-1:0] d,
   input  logic [BUTTON_WIDTH-1:0] repeat_en,
   output logic [BUTTON_WIDTH-1:0] level,
   output logic [BUTTON_WIDTH-1:0] press,
   output logic [BUTTON_WIDTH-1:0] release_pulse,
   output logic [BUTTON_WIDTH-1:0] long_press,
   output logic [BUTTON_WIDTH-1:0] repeat_pulse
);

   localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] RPT_LAST  = CNT_WIDTH'(REPEAT_COUNT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_LONG = 2'd2;

   for (genvar i = 0; i < BUTTON_WIDTH; i++) begin : g_ch
      logic                 s0_q, s1_q;
      logic                 level_q, press_q, release_q;
      logic                 long_q, rpt_q;
      logic [CNT_WIDTH-1:0] db_cnt_q, hold_cnt_q, rpt_cnt_q;
      logic [1:0]           state_q;
      logic                 db_done, rise, fall;

      // A level change is accepted when the mismatch has persisted long enough.
      assign db_done = (db_cnt_q == DB_LAST);
      assign rise    = s1_q & ~level_q & db_done;
      assign fall    = ~s1_q & level_q & db_done;

      // Synchronise the raw input, debounce it and register the edge pulses.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            db_cnt_q  <= '0;
         end else begin
            s0_q      <= d[i];
            s1_q      <= s0_q;
            press_q   <= rise;
            release_q <= fall;
            if (s1_q == level_q) begin
               db_cnt_q <= '0;
            end else if (db_done) begin
               level_q  <= s1_q;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + 1'b1;
            end
         end
      end

      // Hold classifier; an accepted release always wins over a terminal count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            long_q     <= 1'b0;
            rpt_q      <= 1'b0;
         end else begin
            long_q <= 1'b0;
            rpt_q  <= 1'b0;
            case (state_q)
               ST_IDLE: begin
                  if (rise) begin
                     state_q    <= ST_HOLD;
                     hold_cnt_q <= '0;
                  end
               end
               ST_HOLD: begin
                  if (fall) begin
                     state_q    <= ST_IDLE;
                     hold_cnt_q <= '0;
                     rpt_cnt_q  <= '0;
                  end else if (hold_cnt_q == LONG_LAST) begin
                     long_q    <= 1'b1;
                     rpt_cnt_q <= '0;
                     state_q   <= ST_LONG;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end
               ST_LONG: begin
                  if (fall) begin
                     state_q    <= ST_IDLE;
                     hold_cnt_q <= '0;
                     rpt_cnt_q  <= '0;
                  end else if (rpt_cnt_q == RPT_LAST) begin
                     // Period keeps running with repeat_en low so phase is preserved.
                     rpt_cnt_q <= '0;
                     rpt_q     <= repeat_en[i];
                  end else begin
                     rpt_cnt_q <= rpt_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  hold_cnt_q <= '0;
                  rpt_cnt_q  <= '0;
               end
            endcase
         end
      end

      assign level[i]         = level_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;
      assign long_press[i]    = long_q;
      assign repeat_pulse[i]  = rpt_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. A monitor logs every output pulse as
// edge*100 + channel*10 + kind (1 press, 2 release, 3 long, 4 repeat), with
// edges numbered from the first rising edge after reset release; each
// scenario compares that log against a hand-computed event list.
module tb_button_conditioner;

   logic       clk;
   logic       rst_n;
   logic [1:0] d;
   logic [1:0] repeat_en;
   logic [1:0] level;
   logic [1:0] press;
   logic [1:0] release_pulse;
   logic [1:0] long_press;
   logic [1:0] repeat_pulse;

   int checks   = 0;
   int failures = 0;
   int pos_count = 0;
   int base      = 0;
   bit rec_en    = 1'b0;
   int events[$];
   int exp_q[$];

   button_conditioner #(
      .BUTTON_WIDTH    (2),
      .DEBOUNCE_COUNT  (4),
      .LONG_PRESS_COUNT(10),
      .REPEAT_COUNT    (3),
      .CNT_WIDTH       (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d            (d),
      .repeat_en    (repeat_en),
      .level        (level),
      .press        (press),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so scenarios can be timed in edge numbers.
   always @(posedge clk) pos_count <= pos_count + 1;

   // Log output pulses on the falling edge, away from the active edge.
   always @(negedge clk) begin : monitor
      int e;
      logic [3:0] k;
      if (rec_en) begin
         e = pos_count - base - 1;
         for (int ch = 0; ch < 2; ch++) begin
            k = {repeat_pulse[ch], long_press[ch], release_pulse[ch], press[ch]};
            for (int j = 0; j < 4; j++) begin
               if (k[j]) events.push_back(e * 100 + ch * 10 + j + 1);
            end
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_events(input string tag);
      int n;
      check($sformatf("%s.count", tag), events.size(), exp_q.size());
      n = (events.size() > exp_q.size()) ? events.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.ev%0d", tag, i),
               (i < events.size()) ? events[i] : -1,
               (i < exp_q.size()) ? exp_q[i] : -1);
      end
   endtask

   // Reset, then release reset on a falling edge; the next rising edge is edge 0.
   task automatic start(input logic [1:0] d_init, input logic [1:0] en_init);
      rec_en    = 1'b0;
      rst_n     = 1'b0;
      d         = 2'b00;
      repeat_en = 2'b00;
      repeat (3) @(negedge clk);
      events.delete();
      d         = d_init;
      repeat_en = en_init;
      rst_n     = 1'b1;
      base      = pos_count;
      rec_en    = 1'b1;
   endtask

   // Advance to the falling edge just before edge k.
   task automatic to_edge(input int k);
      while (pos_count - base < k) @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      d         = 2'b00;
      repeat_en = 2'b00;
      #2;
      check("reset.outputs", int'({level, press, release_pulse, long_press, repeat_pulse}), 0);

      // Clean press on ch0, no repeat.
      start(2'b01, 2'b00);
      to_edge(26);
      exp_q = '{501, 1503};
      compare_events("clean");
      check("clean.level", int'(level), 1);

      // 3-cycle glitch is rejected.
      start(2'b01, 2'b00);
      to_edge(3);
      d = 2'b00;
      to_edge(16);
      exp_q.delete();
      compare_events("glitch3");
      check("glitch3.level", int'(level), 0);

      // 4-cycle pulse is accepted, then released.
      start(2'b01, 2'b00);
      to_edge(4);
      d = 2'b00;
      to_edge(20);
      exp_q = '{501, 902};
      compare_events("pulse4");

      // Auto-repeat with a gap in repeat_en; phase stays at 3 cycles.
      start(2'b01, 2'b01);
      to_edge(25);
      repeat_en = 2'b00;
      to_edge(31);
      repeat_en = 2'b01;
      to_edge(38);
      exp_q = '{501, 1503, 1804, 2104, 2404, 3304, 3604};
      compare_events("repeat");

      // Release lands on the long-press terminal edge.
      start(2'b01, 2'b00);
      to_edge(10);
      d = 2'b00;
      to_edge(26);
      exp_q = '{501, 1502};
      compare_events("relprio");

      // Reset asserted mid-hold with d still high.
      start(2'b01, 2'b00);
      to_edge(12);
      check("rsthold.level_before", int'(level), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("rsthold.async_clear",
               int'({level, press, release_pulse, long_press, repeat_pulse}), 0);
      exp_q = '{501};
      compare_events("rsthold.pre");
      @(negedge clk);
      @(negedge clk);
      events.delete();
      rst_n = 1'b1;
      base  = pos_count;
      to_edge(13);
      exp_q = '{501};
      compare_events("rsthold.post");

      // Interleaved channels; ch1 release also collides with a repeat edge.
      start(2'b01, 2'b10);
      to_edge(3);
      d = 2'b11;
      to_edge(8);
      d = 2'b10;
      to_edge(16);
      d = 2'b11;
      to_edge(22);
      d = 2'b01;
      to_edge(34);
      exp_q = '{501, 811, 1302, 1813, 2101, 2114, 2414, 2712, 3103};
      compare_events("indep");

      rec_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
